// File: rtl/button_pulse_gen_if.sv
// Button-side signal bundle: the raw button level goes in, and the debounced
// level, the enable pulse and the held flag come back out.
interface button_pulse_gen_if;
    logic btn_in;
    logic btn_level;
    logic en_pulse;
    logic held;

    modport master (
        output btn_in,
        input  btn_level,
        input  en_pulse,
        input  held
    );

    modport slave (
        input  btn_in,
        output btn_level,
        output en_pulse,
        output held
    );
endinterface

// File: rtl/button_pulse_gen.sv
// Pushbutton debouncer that emits one enable pulse per accepted press, then
// auto-repeat pulses while the button stays held.
module button_pulse_gen #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 50000000,
    parameter int REPEAT_PERIOD   = 10000000,
    parameter int REPEAT_EN       = 1,
    parameter int CNT_WIDTH       = 27
) (
    input  logic              clk,
    input  logic              reset,
    button_pulse_gen_if.slave bus
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_PRESS_CHK,
        ST_HELD,
        ST_REPEAT,
        ST_REL_CHK
    } state_t;

    localparam logic [CNT_WIDTH-1:0] DB_LAST  = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] RD_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
    localparam logic [CNT_WIDTH-1:0] RP_LAST  = CNT_WIDTH'(REPEAT_PERIOD - 1);
    localparam logic                 REP_ON   = (REPEAT_EN != 0);

    state_t               state_q, state_d;
    logic                 ret_rep_q, ret_rep_d;
    logic                 s1_q, s2_q;
    logic [CNT_WIDTH-1:0] db_q, db_d;
    logic [CNT_WIDTH-1:0] rep_q, rep_d;
    logic                 btn_level_q, btn_level_d;
    logic                 en_pulse_q, en_pulse_d;
    logic                 held_q, held_d;

    logic                 in_hold;
    logic                 db_diff;
    logic                 db_last;
    logic [CNT_WIDTH-1:0] rep_term;
    logic                 rep_hit;
    logic                 press_accept;

    assign in_hold      = (state_q == ST_HELD) || (state_q == ST_REPEAT);
    assign db_diff      = (s2_q != btn_level_q);
    assign db_last      = (db_q == DB_LAST);
    assign rep_term     = (state_q == ST_REPEAT) ? RP_LAST : RD_LAST;
    assign rep_hit      = REP_ON && in_hold && (rep_q == rep_term);
    assign press_accept = (state_q == ST_PRESS_CHK) && s2_q && db_last;

    // Two-flop synchronizer; nothing downstream looks at s1_q.
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= bus.btn_in;
            s2_q <= s1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            ret_rep_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ret_rep_q <= ret_rep_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        ret_rep_d = ret_rep_q;
        case (state_q)
            ST_IDLE: begin
                if (s2_q) begin
                    state_d = ST_PRESS_CHK;
                end
            end
            ST_PRESS_CHK: begin
                if (!s2_q) begin
                    state_d = ST_IDLE;
                end else if (db_last) begin
                    state_d = ST_HELD;
                end
            end
            ST_HELD, ST_REPEAT: begin
                // A repeat tick that coincides with the first low sample still
                // fires; the low sample then starts the release check.
                ret_rep_d = rep_hit || (state_q == ST_REPEAT);
                if (!s2_q) begin
                    state_d = ST_REL_CHK;
                end else if (rep_hit) begin
                    state_d = ST_REPEAT;
                end
            end
            ST_REL_CHK: begin
                if (s2_q) begin
                    state_d = ret_rep_q ? ST_REPEAT : ST_HELD;
                end else if (db_last) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // The entry cycle counts as the first stable sample, so a level change is
    // accepted on exactly the DEBOUNCE_CYCLES-th consecutive differing sample.
    always_comb begin
        db_d  = '0;
        rep_d = '0;
        if (db_diff && !db_last) begin
            db_d = db_q + CNT_WIDTH'(1);
        end
        case (state_q)
            ST_HELD, ST_REPEAT: begin
                if (!rep_hit && REP_ON) begin
                    rep_d = rep_q + CNT_WIDTH'(1);
                end
            end
            ST_REL_CHK: begin
                rep_d = rep_q;
            end
            default: begin
                rep_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            db_q  <= '0;
            rep_q <= '0;
        end else begin
            db_q  <= db_d;
            rep_q <= rep_d;
        end
    end

    always_comb begin
        btn_level_d = 1'b0;
        held_d      = 1'b0;
        en_pulse_d  = press_accept || rep_hit;
        case (state_d)
            ST_HELD, ST_REPEAT: begin
                btn_level_d = 1'b1;
                held_d      = 1'b1;
            end
            ST_REL_CHK: begin
                btn_level_d = 1'b1;
            end
            default: begin
                btn_level_d = 1'b0;
                held_d      = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            btn_level_q <= 1'b0;
            en_pulse_q  <= 1'b0;
            held_q      <= 1'b0;
        end else begin
            btn_level_q <= btn_level_d;
            en_pulse_q  <= en_pulse_d;
            held_q      <= held_d;
        end
    end

    assign bus.btn_level = btn_level_q;
    assign bus.en_pulse  = en_pulse_q;
    assign bus.held      = held_q;

endmodule

// File: doc/button_pulse_gen.md
# button_pulse_gen

Debounces a raw pushbutton and turns each clean press into a single-cycle enable pulse, with optional auto-repeat while the button is held. It sits directly upstream of the 4-bit counter and drives that counter's `en` input. One `en_pulse` therefore advances the count by exactly one, and holding the button steps the count at a fixed rate.

## Interface
- `DEBOUNCE_CYCLES`, default 1000000: consecutive stable cycles required to accept a level change (10 ms at 100 MHz); must be ≥2.
- `REPEAT_DELAY`, default 50000000: cycles from the press pulse to the first auto-repeat pulse; must be ≥2.
- `REPEAT_PERIOD`, default 10000000: cycles between subsequent auto-repeat pulses; must be ≥2.
- `REPEAT_EN`, default 1: 1 enables auto-repeat, 0 gives press pulses only.
- `CNT_WIDTH`, default 27: width of the internal counters; must hold the largest of the three cycle parameters.
- `clk` input 1: single system clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-low reset; the block is held in reset while `reset`=0.
- `btn_in` input 1: raw, asynchronous, bouncing button level, active-high.
- `btn_level` output 1: debounced button level.
- `en_pulse` output 1: one-cycle enable pulse to the counter's `en`.
- `held` output 1: high while the block is in HELD or REPEAT.

## Operation
- Synchronizer: 2-FF chain `btn_in` → `s1` → `s2`. Only `s2` is used downstream. Both FFs clear to 0 in reset.
- Debounce counter `db_cnt`:
  - Increments each cycle the state is PRESS_CHK or REL_CHK and `s2` differs from `btn_level`.
  - Clears to 0 on any cycle where `s2` equals `btn_level`, i.e. on any bounce.
- FSM states:
  - IDLE: `btn_level`=0. Goes to PRESS_CHK when `s2`=1.
  - PRESS_CHK: if `s2`=0, return to IDLE and clear `db_cnt`. If `db_cnt`=DEBOUNCE_CYCLES-1 and `s2`=1, go to HELD. On that transition `btn_level`←1, `en_pulse`←1 for one cycle, and `rep_cnt`←0.
  - HELD: `btn_level`=1, and `rep_cnt` increments every cycle.
    - If `s2`=0, go to REL_CHK; `rep_cnt` freezes there.
    - If REPEAT_EN=1 and `rep_cnt`=REPEAT_DELAY-1: pulse `en_pulse`, set `rep_cnt`←0, go to REPEAT.
  - REPEAT: same as HELD, except the compare value is REPEAT_PERIOD-1 and the state stays REPEAT after each pulse.
  - REL_CHK: if `s2`=1 (bounce), return to the previous held state (HELD or REPEAT); `rep_cnt` resumes from its frozen value. If `db_cnt`=DEBOUNCE_CYCLES-1 and `s2`=0, go to IDLE with `btn_level`←0. No pulse is generated on release.
- `en_pulse` is never high for two consecutive cycles.
- The pulse width is always exactly 1 clock, independent of hold length.

## Timing
- Reset values: `btn_level`=0, `en_pulse`=0, `held`=0; state IDLE; `db_cnt`=0; `rep_cnt`=0; `s1`=`s2`=0.
- Reset mid-operation: on the first edge with `reset`=0, everything returns to the reset values, including an in-flight `en_pulse`, which is dropped.
  - After `reset` returns to 1, a button still held is treated as a new press: full sync and debounce, then one pulse.
- Press latency: let edge 0 be the first edge that samples `btn_in`=1, with `btn_in` held stable.
  - `s2`=1 after edge 1.
  - `btn_level` and `en_pulse` are high after edge 1+DEBOUNCE_CYCLES.
- Repeat latency:
  - First repeat pulse: exactly REPEAT_DELAY cycles after the press pulse.
  - Later repeat pulses: every REPEAT_PERIOD cycles.
- Release latency: `btn_level` falls 1+DEBOUNCE_CYCLES edges after the first edge sampling `btn_in`=0.
- All outputs are registered; there is no combinational path from `btn_in`.
- Counter widths: compares use equality only. The counters cannot overflow because they are cleared or reloaded at their terminal values.

## Test plan
- Parameters for all scenarios: DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3, REPEAT_EN=1.
- Reset: hold `reset`=0 for 3 cycles with `btn_in`=1 → all outputs 0. Release reset with `btn_in` still 1 → exactly one `en_pulse`, 5 edges later.
- Clean press: raise `btn_in` and hold it for 8 cycles, then drop it → one `en_pulse` at edge 5 and `btn_level`=1 from edge 5. After release, `btn_level` returns to 0 five edges after the first 0 sample, with no pulse on release.
- Bounce: toggle `btn_in` 1,0,1,0 on successive cycles, then hold it at 1 → no pulse during the toggling; a single pulse 5 edges after the final stable rise.
- Auto-repeat: hold `btn_in`=1 for 30 cycles after acceptance → pulses at cycle offsets 0, 10, 13, 16, 19, 22, 25, 28 relative to the press pulse. With the counter attached, `counter_out` advances by 8.
- Release bounce: while in REPEAT, drop `btn_in` for 2 cycles, then restore it → `btn_level` stays 1, and the next repeat pulse is delayed by exactly the 2 frozen cycles.
- REPEAT_EN=0: hold the button for 40 cycles → exactly one `en_pulse`.
